// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage for the MIPS single-cycle core. Owns the program
// counter, fetches one instruction word at a time over a variable-latency
// request/acknowledge handshake, holds it for exactly one execute cycle and
// then forms the next PC from the controller's branch/jump decisions.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset_n      asynchronous active-low reset
//   imem_req     fetch request, held high until acknowledged
//   imem_addr    byte address of the requested word (always the current PC)
//   imem_ack     memory has valid imem_rdata this cycle
//   imem_rdata   instruction word, captured on an acknowledged FETCH edge
//   instr        latched instruction
//   op, funct    instr[31:26] and instr[5:0], to the controller
//   instr_valid  one-cycle execute/commit strobe; datapath writes only then
//   pc           current PC
//   pcplus4      pc + 4, for the datapath (link value, branch base)
//   pcsrc        take branch (already resolved by the controller)
//   jump         take jump (wins over pcsrc)
//   signimm      sign-extended immediate from the datapath
//   halt         stop fetching once the current instruction commits
//   halted       high while parked in the HALTED state
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [31:0] signimm,
    input  logic        halt,
    output logic        halted
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] next_pc;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // All handshake and strobe outputs are decoded from registered state only,
    // so a reset assertion removes instr_valid immediately and imem_addr can
    // never move while a request is outstanding.
    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALTED);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];

    // PC arithmetic is plain modulo-2^32; wrap-around past the top or below
    // zero is intentional and raises nothing.
    assign pcplus4       = pc_q + 32'd4;
    assign branch_target = pcplus4 + (signimm << 2);
    assign jump_target   = {pcplus4[31:28], instr_q[25:0], 2'b00};

    // Jump takes priority over a branch when the controller asserts both.
    always_comb begin
        next_pc = pcplus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (pcsrc) begin
            next_pc = branch_target;
        end
    end

    // Next-state logic. The ack is only honoured in FETCH; the PC only moves
    // on the EXEC edge, and halt is only looked at there too.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_d    = next_pc;
                state_d = halt ? HALTED : FETCH;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Architectural state with asynchronous reset back to a fresh fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A table of per-cycle records walks the PC
// through reset, wait states, branches, jump-over-branch, wrap-around and
// halt; hand-written sequences cover the halted hold and reset mid-EXEC.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic        halt;
    logic        halted;

    int vectorsApplied;
    int miscompares;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        pcsrc;
        logic        jump;
        logic [31:0] signimm;
        logic        halt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic        halted;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pcplus4     (pcplus4),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .signimm     (signimm),
        .halt        (halt),
        .halted      (halted)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Appends one cycle record: inputs first, then the outputs expected
    // during that same cycle (before the following rising edge).
    task automatic addVec(
        input logic ack, input logic [31:0] rdata, input logic ps, input logic jmp,
        input logic [31:0] simm, input logic hlt,
        input logic req, input logic [31:0] addr, input logic valid,
        input logic [5:0] eop, input logic [5:0] efunct,
        input logic [31:0] epc, input logic [31:0] epc4, input logic ehalted);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.pcsrc = ps; v.jump = jmp;
        v.signimm = simm; v.halt = hlt;
        v.req = req; v.addr = addr; v.valid = valid; v.op = eop; v.funct = efunct;
        v.pc = epc; v.pcplus4 = epc4; v.halted = ehalted;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        imem_ack   = v.ack;
        imem_rdata = v.rdata;
        pcsrc      = v.pcsrc;
        jump       = v.jump;
        signimm    = v.signimm;
        halt       = v.halt;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        logic [111:0] act;
        logic [111:0] exp;
        act = {imem_req, imem_addr, instr_valid, op, funct, pc, pcplus4, halted};
        exp = {v.req, v.addr, v.valid, v.op, v.funct, v.pc, v.pcplus4, v.halted};
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL vec%0d: got req=%b addr=%h valid=%b op=%h funct=%h pc=%h pc4=%h halted=%b, want req=%b addr=%h valid=%b op=%h funct=%h pc=%h pc4=%h halted=%b",
                     idx, imem_req, imem_addr, instr_valid, op, funct, pc, pcplus4, halted,
                     v.req, v.addr, v.valid, v.op, v.funct, v.pc, v.pcplus4, v.halted);
        end
    endtask

    task automatic checkSig(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Cycle-by-cycle program. Targets were worked out by hand:
    //   0x48 + 0x2E*4          = 0x100
    //   0x104 + (-2)*4         = 0xFC
    //   0x100 + 0x23FFFFC0*4   = 0x9000_0000
    //   jump {9, 0x10<<2}      = 0x9000_0040 (branch would give 0x9000_0404)
    //   0x9000_0044 + 0x1BFFFFEE*4 = 0xFFFF_FFFC
    task automatic buildVectors();
        //     ack rdata         ps jmp simm          hlt  req addr          vld op     funct  pc            pc4           hltd
        addVec(1, 32'h2008_0005, 0, 0, 32'h0,         0,   1, 32'h0000_0040, 0, 6'h00, 6'h00, 32'h0000_0040, 32'h0000_0044, 0);
        addVec(0, 32'h0,         0, 0, 32'h0,         0,   0, 32'h0000_0040, 1, 6'h08, 6'h05, 32'h0000_0040, 32'h0000_0044, 0);
        addVec(0, 32'hDEAD_BEEF, 0, 0, 32'h0,         0,   1, 32'h0000_0044, 0, 6'h08, 6'h05, 32'h0000_0044, 32'h0000_0048, 0);
        addVec(0, 32'hDEAD_BEEF, 0, 0, 32'h0,         0,   1, 32'h0000_0044, 0, 6'h08, 6'h05, 32'h0000_0044, 32'h0000_0048, 0);
        addVec(0, 32'hDEAD_BEEF, 0, 0, 32'h0,         0,   1, 32'h0000_0044, 0, 6'h08, 6'h05, 32'h0000_0044, 32'h0000_0048, 0);
        addVec(1, 32'h1000_FFFE, 0, 0, 32'h0,         0,   1, 32'h0000_0044, 0, 6'h08, 6'h05, 32'h0000_0044, 32'h0000_0048, 0);
        addVec(0, 32'h0,         1, 0, 32'h0000_002E, 0,   0, 32'h0000_0044, 1, 6'h04, 6'h3E, 32'h0000_0044, 32'h0000_0048, 0);
        addVec(1, 32'h1000_FFFE, 0, 0, 32'h0,         0,   1, 32'h0000_0100, 0, 6'h04, 6'h3E, 32'h0000_0100, 32'h0000_0104, 0);
        addVec(0, 32'h0,         1, 0, 32'hFFFF_FFFE, 0,   0, 32'h0000_0100, 1, 6'h04, 6'h3E, 32'h0000_0100, 32'h0000_0104, 0);
        addVec(1, 32'h1000_0001, 0, 0, 32'h0,         0,   1, 32'h0000_00FC, 0, 6'h04, 6'h3E, 32'h0000_00FC, 32'h0000_0100, 0);
        addVec(0, 32'h0,         1, 0, 32'h23FF_FFC0, 0,   0, 32'h0000_00FC, 1, 6'h04, 6'h01, 32'h0000_00FC, 32'h0000_0100, 0);
        addVec(1, 32'h0800_0010, 0, 0, 32'h0,         0,   1, 32'h9000_0000, 0, 6'h04, 6'h01, 32'h9000_0000, 32'h9000_0004, 0);
        addVec(0, 32'h0,         1, 1, 32'h0000_0100, 0,   0, 32'h9000_0000, 1, 6'h02, 6'h10, 32'h9000_0000, 32'h9000_0004, 0);
        addVec(1, 32'h1000_0002, 0, 0, 32'h0,         0,   1, 32'h9000_0040, 0, 6'h02, 6'h10, 32'h9000_0040, 32'h9000_0044, 0);
        addVec(0, 32'h0,         1, 0, 32'h1BFF_FFEE, 0,   0, 32'h9000_0040, 1, 6'h04, 6'h02, 32'h9000_0040, 32'h9000_0044, 0);
        addVec(1, 32'h0000_0020, 0, 0, 32'h0,         0,   1, 32'hFFFF_FFFC, 0, 6'h04, 6'h02, 32'hFFFF_FFFC, 32'h0000_0000, 0);
        // Stray ack during EXEC must not overwrite the held instruction.
        addVec(1, 32'hFFFF_FFFF, 0, 0, 32'h0,         0,   0, 32'hFFFF_FFFC, 1, 6'h00, 6'h20, 32'hFFFF_FFFC, 32'h0000_0000, 0);
        // Halt during FETCH is ignored.
        addVec(0, 32'h0,         0, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 6'h00, 6'h20, 32'h0000_0000, 32'h0000_0004, 0);
        addVec(1, 32'h0800_0008, 0, 0, 32'h0,         1,   1, 32'h0000_0000, 0, 6'h00, 6'h20, 32'h0000_0000, 32'h0000_0004, 0);
        addVec(0, 32'h0,         0, 1, 32'h0,         0,   0, 32'h0000_0000, 1, 6'h02, 6'h08, 32'h0000_0000, 32'h0000_0004, 0);
        addVec(1, 32'h0000_000C, 0, 0, 32'h0,         0,   1, 32'h0000_0020, 0, 6'h02, 6'h08, 32'h0000_0020, 32'h0000_0024, 0);
        addVec(0, 32'h0,         0, 0, 32'h0,         1,   0, 32'h0000_0020, 1, 6'h00, 6'h0C, 32'h0000_0020, 32'h0000_0024, 0);
        addVec(1, 32'h1234_5678, 0, 0, 32'h0,         0,   0, 32'h0000_0024, 0, 6'h00, 6'h0C, 32'h0000_0024, 32'h0000_0028, 1);
    endtask

    initial begin
        vectorsApplied = 0;
        miscompares    = 0;
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        signimm    = 32'h0;
        halt       = 1'b0;
        buildVectors();

        // Reset state while reset_n is held low.
        #12;
        checkSig("rstReq",    {31'h0, imem_req},    32'h1);
        checkSig("rstAddr",   imem_addr,            RST_PC);
        checkSig("rstValid",  {31'h0, instr_valid}, 32'h0);
        checkSig("rstHalted", {31'h0, halted},      32'h0);
        checkSig("rstInstr",  instr,                32'h0);
        checkSig("rstPc4",    pcplus4,              32'h0000_0044);
        @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1 checkOutput(vecs[i], i);
        end

        // Halted: no requests for 20 cycles even with acks arriving.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            imem_ack = i[0];
            #1 checkSig("haltNoReq", {31'h0, imem_req}, 32'h0);
        end
        checkSig("haltPc",     pc,                   32'h0000_0024);
        checkSig("haltFlag",   {31'h0, halted},      32'h1);

        // Reset leaves HALTED and restarts at the reset PC.
        @(negedge clk);
        imem_ack = 1'b0;
        reset_n  = 1'b0;
        #1 checkSig("unhaltAsync", {31'h0, halted}, 32'h0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h2008_0005;
        #1 checkSig("restartAddr", imem_addr, RST_PC);
        @(negedge clk);
        imem_ack = 1'b0;
        jump     = 1'b1;
        #1 checkSig("midExecValid", {31'h0, instr_valid}, 32'h1);

        // Reset mid-EXEC: strobe drops at once and the jump is discarded.
        #1 reset_n = 1'b0;
        #1 checkSig("rstDropValid", {31'h0, instr_valid}, 32'h0);
        checkSig("rstKeepPc", pc, RST_PC);
        @(posedge clk);
        #2 reset_n = 1'b1;
        jump = 1'b0;
        @(negedge clk);
        #1 checkSig("postRstReq",  {31'h0, imem_req}, 32'h1);
        checkSig("postRstAddr", imem_addr, RST_PC);

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the MIPS single-cycle core; sits directly upstream of the controller and datapath. Owns the program counter and issues requests to an instruction memory with variable-latency request/acknowledge handshake. Holds each fetched instruction stable for one execute cycle, then takes the controller's `pcsrc`/`jump` decisions to form the next PC. Presents `op`/`funct` to the controller, and a one-cycle `instr_valid` strobe that gates all architectural writes.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word-aligned)
- `clk`  in  1  single clock, all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request, held until acknowledged
- `imem_addr`  out  32  byte address of requested word (= `pc`)
- `imem_ack`  in  1  memory has valid `imem_rdata` this cycle
- `imem_rdata`  in  32  instruction word, sampled when `imem_req & imem_ack`
- `instr`  out  32  latched instruction
- `op`  out  6  `instr[31:26]`, to controller
- `funct`  out  6  `instr[5:0]`, to controller
- `instr_valid`  out  1  execute/commit strobe; datapath writes only when high
- `pc`  out  32  current PC
- `pcplus4`  out  32  `pc + 4`, for datapath (jal-style uses, branch base)
- `pcsrc`  in  1  from controller: take branch (beq/bne already resolved)
- `jump`  in  1  from controller: take jump
- `signimm`  in  32  sign-extended immediate from datapath
- `halt`  in  1  stop fetching after the current instruction commits
- `halted`  out  1  high in HALTED state

## Operation
- FSM states: FETCH, EXEC, HALTED.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On an edge with `imem_ack`=1: `instr`<=`imem_rdata`, go to EXEC. Otherwise stay; `pc` and `instr` unchanged.
- EXEC: `instr_valid`=1, `imem_req`=0. `pcsrc`/`jump`/`signimm` are evaluated combinationally from the held `instr`. On the edge:
  - `pc`<=`next_pc`.
  - If `halt`=1, go to HALTED; else go to FETCH.
- HALTED: `imem_req`=0, `instr_valid`=0, `halted`=1. Only exit is reset.
- `next_pc` priority:
  - `jump`=1: `{pcplus4[31:28], instr[25:0], 2'b00}`
  - else `pcsrc`=1: `pcplus4 + (signimm << 2)`
  - else: `pcplus4`
- Arithmetic is 32-bit modulo 2^32. `pcplus4` wraps 32'hFFFF_FFFC -> 32'h0000_0000. A backward branch below 0 also wraps. No exception is raised.
- `jump` and `pcsrc` both high: jump wins.
- `op`/`funct` are pure slices of `instr`. They are stable for the whole EXEC cycle and for FETCH cycles (old instruction), but are meaningful only when `instr_valid`=1.
- `imem_ack` is ignored outside FETCH. An ack arriving in EXEC/HALTED has no effect.

## Timing
- Reset (async assert, any state): state=FETCH, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `halted`=0.
  - Because the reset state is FETCH, `imem_req` is high immediately after deassertion; `imem_addr`=`RESET_PC`.
- Reset deassertion is sampled on the rising edge. The first request is visible in the first cycle with `reset_n`=1.
- Ack may be combinational in the same cycle as the request (zero-wait memory). Minimum throughput is 2 cycles per instruction (FETCH, EXEC).
- With N wait cycles (ack in the (N+1)th FETCH cycle), the instruction takes N+2 cycles.
- `instr_valid` is exactly one cycle wide per fetched instruction and is never high in consecutive cycles.
- `imem_addr` stays constant while `imem_req` is high and unacknowledged.
- Reset mid-EXEC: the commit is suppressed. `instr_valid` drops asynchronously and the PC update is lost.
- `halt` is sampled only in EXEC. `halt` high in FETCH has no effect until the following EXEC.

## Test plan
- Reset/first fetch:
  - Stimulus: `RESET_PC`=32'h0000_0040, zero-wait memory returning 32'h2008_0005, `pcsrc`=`jump`=0.
  - Required: `imem_addr`=0x40 in the first cycle; `instr_valid` high in the second with `op`=6'h08; then `pc`=0x44 and a FETCH at 0x44.
- Wait states:
  - Stimulus: ack held off 3 cycles.
  - Required: `imem_req` and `imem_addr` stable for all 4 FETCH cycles; `instr_valid` asserted once, 5 cycles after the request starts.
- Branch:
  - Stimulus: `pc`=0x100; in EXEC drive `pcsrc`=1, `signimm`=32'hFFFF_FFFE.
  - Required: next `imem_addr`=0x104 + (-8) = 0xFC.
- Jump over branch:
  - Stimulus: `pc`=0x9000_0000, `instr[25:0]`=26'h000_0010, `jump`=1 and `pcsrc`=1.
  - Required: next PC=0x9000_0040.
- Wrap:
  - Stimulus: `pc`=0xFFFF_FFFC, no branch.
  - Required: `pcplus4`=0 and next fetch at 0x0.
- Halt and reset:
  - Stimulus: `halt`=1 during EXEC at pc 0x20.
  - Required: `pc`=0x24, `halted`=1, no further `imem_req` for 20 cycles.
  - Stimulus: `reset_n` pulsed low mid-EXEC.
  - Required: `instr_valid` drops immediately; after release, fetch restarts at `RESET_PC`.
